// File: rtl/heat_mode_actuator.sv
// heat_mode_actuator: one-hot heating enable stage with dead time, min-on/min-off timing and fault shutdown
module heat_mode_actuator #(
  parameter int MIN_ON_CYCLES   = 16,
  parameter int MIN_OFF_CYCLES  = 16,
  parameter int DEADTIME_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_sel,
  input  logic       req_on,
  output logic       req_ready,
  input  logic       fault,
  output logic [1:0] heat_en,
  output logic       active_sel,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {S_OFF = 2'd0, S_DEAD = 2'd1, S_ON = 2'd2, S_FAULT = 2'd3} state_t;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] MIN_ON  = CNT_W'(MIN_ON_CYCLES);
  localparam logic [CNT_W-1:0] MIN_OFF = CNT_W'(MIN_OFF_CYCLES);
  localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEADTIME_CYCLES - 1);
  if (MIN_ON_CYCLES < 1 || MIN_ON_CYCLES > CNT_MAX || MIN_OFF_CYCLES < 1 || MIN_OFF_CYCLES > CNT_MAX ||
      DEADTIME_CYCLES < 1 || DEADTIME_CYCLES > CNT_MAX) begin : g_bad_param
    $error("heat_mode_actuator: timing parameter out of range for CNT_W");
  end
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
  logic             target_q, target_d, active_sel_q, active_sel_d;
  logic [1:0]       heat_en_q, heat_en_d;
  logic             acc;
  assign req_ready = !fault && (state_q == S_OFF ? (cnt_q >= MIN_OFF || !req_on) :
                                state_q == S_ON  ? cnt_q >= MIN_ON : 1'b0);
  assign acc        = req_valid && req_ready;
  assign cnt_sat    = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
  assign heat_en    = heat_en_q;
  assign active_sel = active_sel_q;
  assign state_o    = state_q;
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    active_sel_d = active_sel_q;
    heat_en_d    = heat_en_q;
    if (fault) begin
      state_d   = S_FAULT;
      heat_en_d = 2'b00;
    end else begin
      case (state_q)
        S_OFF: if (acc && req_on) begin
          state_d      = S_DEAD;
          target_d     = req_sel;
          active_sel_d = req_sel;
        end
        S_DEAD: if (cnt_q == DT_LAST) begin
          state_d   = S_ON;
          heat_en_d = target_q ? 2'b10 : 2'b01;
        end
        S_ON: if (acc && !req_on) begin
          state_d   = S_OFF;
          heat_en_d = 2'b00;
        end else if (acc && req_sel != target_q) begin
          state_d      = S_DEAD;
          target_d     = req_sel;
          active_sel_d = req_sel;
          heat_en_d    = 2'b00;
        end
        default: state_d = S_OFF;
      endcase
    end
    cnt_d = state_d != state_q ? '0 : cnt_sat;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_OFF;
      cnt_q        <= MIN_OFF;
      target_q     <= 1'b0;
      active_sel_q <= 1'b0;
      heat_en_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      target_q     <= target_d;
      active_sel_q <= active_sel_d;
      heat_en_q    <= heat_en_d;
    end
  end
endmodule
